vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_pkg.sv | 18 +
 rtl/sig_delay.sv | 25 ++
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 tb/tb_vga_timing_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and the total-period helper used by the raster generator.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_PIPE_DLY = 2;

    function automatic int span_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift register; resets every stage to zero and shifts on every clock.
module sig_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: issues pixel fetch requests, then realigns sync/blank with the
// returning colour after the upstream fetch + colour-conversion pipeline.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int PIPE_DLY = DEF_PIPE_DLY,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic        pix_req,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        frame_start,
    output logic        line_start,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic        in_active;
    logic        in_hs;
    logic        in_vs;
    logic        hs_int;
    logic        vs_int;
    logic [2:0]  dly_in;
    logic [2:0]  dly_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (!enable) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? 11'd0 : vcnt + 11'd1;
        end else begin
            hcnt <= hcnt + 11'd1;
        end
    end

    // Gating with enable keeps the held (0,0) position from issuing requests while stopped.
    assign in_active = enable && (hcnt < H_ACT) && (vcnt < V_ACT);
    assign in_hs     = enable && (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
    assign in_vs     = enable && (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_req     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            hs_int      <= 1'b0;
            vs_int      <= 1'b0;
        end else begin
            pix_req     <= in_active;
            pix_x       <= in_active ? hcnt : 11'd0;
            pix_y       <= in_active ? vcnt : 11'd0;
            frame_start <= in_active && (hcnt == 11'd0) && (vcnt == 11'd0);
            line_start  <= in_active && (hcnt == 11'd0);
            hs_int      <= in_hs;
            vs_int      <= in_vs;
        end
    end

    assign dly_in = {pix_req, hs_int, vs_int};

    sig_delay #(
        .WIDTH (3),
        .DEPTH (PIPE_DLY)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (dly_in),
        .dout  (dly_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_de <= 1'b0;
            vga_hs <= ~SYNC_POL;
            vga_vs <= ~SYNC_POL;
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
        end else begin
            vga_de <= dly_out[2];
            vga_hs <= dly_out[1] ? SYNC_POL : ~SYNC_POL;
            vga_vs <= dly_out[0] ? SYNC_POL : ~SYNC_POL;
            vga_r  <= dly_out[2] ? r : 8'd0;
            vga_g  <= dly_out[2] ? g : 8'd0;
            vga_b  <= dly_out[2] ? b : 8'd0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small raster and a full-width raster, each compared cycle by
// cycle against a pixel-index model plus direct period/offset measurements.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en_a, en_b;
    logic [7:0] r, g, b;

    logic        a_req, a_fs, a_ls, a_hs, a_vs, a_de;
    logic [10:0] a_x, a_y;
    logic [7:0]  a_r, a_g, a_b;
    logic        b_req, b_fs, b_ls, b_hs, b_vs, b_de;
    logic [10:0] b_x, b_y;
    logic [7:0]  b_r, b_g, b_b;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIPE_DLY(2), .SYNC_POL(1'b0)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .r(r), .g(g), .b(b),
        .pix_req(a_req), .pix_x(a_x), .pix_y(a_y), .frame_start(a_fs), .line_start(a_ls),
        .vga_hs(a_hs), .vga_vs(a_vs), .vga_de(a_de), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b)
    );

    vga_timing_gen #(
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .PIPE_DLY(3)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .r(r), .g(g), .b(b),
        .pix_req(b_req), .pix_x(b_x), .pix_y(b_y), .frame_start(b_fs), .line_start(b_ls),
        .vga_hs(b_hs), .vga_vs(b_vs), .vga_de(b_de), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b)
    );

    logic        sel;
    logic        o_req, o_fs, o_ls, o_hs, o_vs, o_de;
    logic [10:0] o_x, o_y;
    logic [7:0]  o_r, o_g, o_b;

    always_comb begin
        o_req = sel ? b_req : a_req;
        o_fs  = sel ? b_fs  : a_fs;
        o_ls  = sel ? b_ls  : a_ls;
        o_hs  = sel ? b_hs  : a_hs;
        o_vs  = sel ? b_vs  : a_vs;
        o_de  = sel ? b_de  : a_de;
        o_x   = sel ? b_x   : a_x;
        o_y   = sel ? b_y   : a_y;
        o_r   = sel ? b_r   : a_r;
        o_g   = sel ? b_g   : a_g;
        o_b   = sel ? b_b   : a_b;
    end

    typedef struct {
        bit         de, hs, vs, fs, ls;
        int         x, y;
        logic [7:0] cr, cg, cb;
    } rec_t;

    rec_t hq[$];
    int   errors = 0;
    int   checks = 0;
    int   ha, hf, hsw, hb, va, vf, vsw, vb, pd, ht, vt;
    int   pos, cyc;
    bit   blank_ff, trk;
    int   run, fs_cyc, de_rise, hs_fall, vs_fall, n_hs, n_vs, de_cnt;
    bit   have_fs, have_de, have_hf, have_vf, prev_de, prev_hs, prev_vs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expd, cyc);
        end
    endtask

    function automatic rec_t zero_rec();
        rec_t z;
        z.de = 0; z.hs = 0; z.vs = 0; z.fs = 0; z.ls = 0;
        z.x = 0; z.y = 0; z.cr = 0; z.cg = 0; z.cb = 0;
        return z;
    endfunction

    task automatic set_params(input int p_ha, p_hf, p_hs, p_hb, p_va, p_vf, p_vs, p_vb, p_pd);
        ha = p_ha; hf = p_hf; hsw = p_hs; hb = p_hb;
        va = p_va; vf = p_vf; vsw = p_vs; vb = p_vb; pd = p_pd;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
    endtask

    // Raster position is a linear pixel index into the frame; h and v fall out by div/mod.
    task automatic model_edge();
        rec_t s;
        int   h, v;
        bit   en_now;
        s = zero_rec();
        en_now = sel ? en_b : en_a;
        if (rst_n && en_now) begin
            h = pos % ht;
            v = pos / ht;
            s.de = (h < ha) && (v < va);
            s.hs = (h >= ha + hf) && (h < ha + hf + hsw);
            s.vs = (v >= va + vf) && (v < va + vf + vsw);
            s.fs = s.de && h == 0 && v == 0;
            s.ls = s.de && h == 0;
            if (s.de) begin
                s.x = h; s.y = v;
                s.cr = 8'(h + 1); s.cg = 8'($urandom); s.cb = 8'($urandom);
            end
            pos = (pos + 1) % (ht * vt);
        end else begin
            pos = 0;
        end
        hq.push_front(s);
        if (hq.size() > 16) void'(hq.pop_back());
    endtask

    task automatic check_outputs();
        rec_t s, o;
        s = hq[0];
        o = hq[pd + 1];
        chk("pix_req", 32'(o_req), 32'(s.de));
        chk("pix_x", 32'(o_x), s.x);
        chk("pix_y", 32'(o_y), s.y);
        chk("frame_start", 32'(o_fs), 32'(s.fs));
        chk("line_start", 32'(o_ls), 32'(s.ls));
        chk("vga_de", 32'(o_de), 32'(o.de));
        chk("vga_hs", 32'(o_hs), 32'(!o.hs));
        chk("vga_vs", 32'(o_vs), 32'(!o.vs));
        chk("vga_r", 32'(o_r), o.de ? 32'(o.cr) : 32'd0);
        chk("vga_g", 32'(o_g), o.de ? 32'(o.cg) : 32'd0);
        chk("vga_b", 32'(o_b), o.de ? 32'(o.cb) : 32'd0);
    endtask

    task automatic track();
        if (trk) begin
            if (o_req) run++;
            else begin
                if (run != 0) chk("req_run", run, ha);
                run = 0;
            end
            if (o_fs) begin
                if (have_fs) chk("fs_period", cyc - fs_cyc, ht * vt);
                have_fs = 1; fs_cyc = cyc;
            end
            if (o_de && !prev_de) begin de_rise = cyc; have_de = 1; end
            if (!o_hs && prev_hs) begin
                if (have_de && cyc - de_rise < ht) chk("hs_offset", cyc - de_rise, ha + hf);
                if (have_hf) chk("hs_period", cyc - hs_fall, ht);
                have_hf = 1; hs_fall = cyc; n_hs++;
            end
            if (o_hs && !prev_hs && have_hf) chk("hs_width", cyc - hs_fall, hsw);
            if (!o_vs && prev_vs) begin
                if (have_fs) chk("vs_offset", cyc - fs_cyc, (va + vf) * ht + pd + 1);
                if (have_vf) chk("vs_period", cyc - vs_fall, ht * vt);
                have_vf = 1; vs_fall = cyc; n_vs++;
            end
            if (o_vs && !prev_vs && have_vf) chk("vs_width", cyc - vs_fall, vsw * ht);
        end
        prev_de = o_de; prev_hs = o_hs; prev_vs = o_vs;
    endtask

    task automatic drive();
        rec_t d;
        d = hq[pd];
        if (d.de) begin
            r = d.cr; g = d.cg; b = d.cb;
        end else if (blank_ff) begin
            r = 8'hFF; g = 8'hFF; b = 8'hFF;
        end else begin
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        check_outputs();
        track();
        drive();
    endtask

    task automatic clear_track();
        run = 0; have_fs = 0; have_de = 0; have_hf = 0; have_vf = 0;
        prev_de = 0; prev_hs = 1; prev_vs = 1;
    endtask

    // Asserts reset between clock edges and checks both instances before any edge arrives.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_a_ctl", 32'({a_req, a_fs, a_ls, a_de, a_hs, a_vs}), 32'b000011);
        chk("rst_a_xy",  32'({a_x, a_y}), 32'd0);
        chk("rst_a_rgb", 32'({a_r, a_g, a_b}), 32'd0);
        chk("rst_b_ctl", 32'({b_req, b_fs, b_ls, b_de, b_hs, b_vs}), 32'b000011);
        chk("rst_b_xy",  32'({b_x, b_y}), 32'd0);
        chk("rst_b_rgb", 32'({b_r, b_g, b_b}), 32'd0);
        hq.delete();
        repeat (16) hq.push_back(zero_rec());
        pos = 0;
        clear_track();
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; sel = 1'b0;
        r = 8'hFF; g = 8'hFF; b = 8'hFF;
        cyc = 0; pos = 0; n_hs = 0; n_vs = 0; trk = 0; blank_ff = 1;
        set_params(8, 2, 2, 2, 4, 1, 1, 1, 2);
        repeat (16) hq.push_back(zero_rec());
        clear_track();
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Small raster, continuous enable, constant 0xFF colour outside active video.
        en_a = 1'b1; trk = 1;
        repeat (300) step();

        // Reset in the middle of an active line.
        for (int i = 0; i < 100 && !(pos % ht == 5 && pos / ht < va); i++) step();
        chk("reach_midline", pos % ht, 5);
        do_reset();
        repeat (40) step();

        // Enable dropped with the counters at (3,1).
        trk = 0;
        for (int i = 0; i < 200 && pos != ht + 3; i++) step();
        chk("reach_3_1", pos, ht + 3);
        en_a = 1'b0;
        de_cnt = 0;
        repeat (8) begin
            step();
            if (o_de) de_cnt++;
        end
        chk("drain_count", de_cnt, 3);
        en_a = 1'b1;
        step();
        chk("restart_fs", 32'(o_fs), 32'd1);
        chk("restart_xy", 32'({o_x, o_y}), 32'd0);
        repeat (20) step();

        // Random enable toggling with random colour on blanked cycles.
        blank_ff = 0;
        repeat (600) begin
            if ($urandom_range(0, 29) == 0) en_a = ~en_a;
            step();
        end
        chk("a_hs_seen", 32'(n_hs > 0), 32'd1);
        chk("a_vs_seen", 32'(n_vs > 0), 32'd1);

        // Full-width raster with the default horizontal timing.
        en_a = 1'b0;
        sel = 1'b1;
        set_params(640, 16, 96, 48, 6, 2, 2, 2, 3);
        n_hs = 0; n_vs = 0;
        do_reset();
        en_b = 1'b1; trk = 1; blank_ff = 1;
        repeat (2 * 800 * 12 + 900) step();
        chk("b_hs_seen", 32'(n_hs > 0), 32'd1);
        chk("b_vs_seen", 32'(n_vs > 1), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
